// File: rtl/apb_bridge_master.sv
// APB initiator: latches one processor request and runs a SETUP/ACCESS transfer on the
// shared APB outputs, returning read data plus a completion/error pulse to the processor.
module apb_bridge_master #(
  parameter logic [1:0] ID1     = 2'd1,
  parameter logic [1:0] ID2     = 2'd2,
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       proc_start,
  input  logic       proc_write,
  input  logic [1:0] proc_sel,
  input  logic [7:0] proc_addr,
  input  logic [7:0] proc_wdata,
  input  logic [7:0] proc_wait_cycles,
  output logic [7:0] proc_rdata,
  output logic       proc_stable,
  output logic       proc_err,
  output logic [1:0] apb_sel,
  output logic       apb_enable,
  output logic       apb_write,
  output logic [7:0] apb_addr,
  output logic [7:0] apb_wdata,
  output logic [7:0] apb_wait_cycles,
  input  logic       apb1_ready,
  input  logic [7:0] apb1_rdata,
  input  logic       apb2_ready,
  input  logic [7:0] apb2_rdata
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       flag_q, flag_d;
  logic       write_q, write_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] rdata_q, rdata_d;
  logic [1:0] apb_sel_q, apb_sel_d;
  logic       enable_q, enable_d;
  logic       stable_q, stable_d;
  logic       perr_q, perr_d;

  logic       sel_ok;
  logic       seg_ready;
  logic [7:0] seg_rdata;

  assign sel_ok    = (proc_sel == ID1) || (proc_sel == ID2);
  // Only the latched segment is listened to; the other segment's ready is ignored.
  assign seg_ready = (sel_q == ID1) ? apb1_ready : apb2_ready;
  assign seg_rdata = (sel_q == ID1) ? apb1_rdata : apb2_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    write_d = write_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        cnt_d  = 8'd0;
        flag_d = 1'b0;
        if (proc_start) begin
          if (sel_ok) begin
            write_d = proc_write;
            sel_d   = proc_sel;
            addr_d  = proc_addr;
            wdata_d = proc_wdata;
            wait_d  = proc_wait_cycles;
            state_d = StSetup;
          end else begin
            flag_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (seg_ready) begin
          if (!write_q) rdata_d = seg_rdata;
          state_d = StDone;
        end else if (cnt_q == TIMEOUT - 8'd1) begin
          flag_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        cnt_d   = 8'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the next state.
    apb_sel_d = ((state_d == StSetup) || (state_d == StAccess)) ? sel_d : 2'd0;
    enable_d  = (state_d == StAccess);
    stable_d  = (state_d == StDone);
    perr_d    = (state_d == StDone) && flag_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      flag_q    <= 1'b0;
      write_q   <= 1'b0;
      sel_q     <= 2'd0;
      addr_q    <= 8'd0;
      wdata_q   <= 8'd0;
      wait_q    <= 8'd0;
      rdata_q   <= 8'd0;
      apb_sel_q <= 2'd0;
      enable_q  <= 1'b0;
      stable_q  <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flag_q    <= flag_d;
      write_q   <= write_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wait_q    <= wait_d;
      rdata_q   <= rdata_d;
      apb_sel_q <= apb_sel_d;
      enable_q  <= enable_d;
      stable_q  <= stable_d;
      perr_q    <= perr_d;
    end
  end

  assign proc_rdata      = rdata_q;
  assign proc_stable     = stable_q;
  assign proc_err        = perr_q;
  assign apb_sel         = apb_sel_q;
  assign apb_enable      = enable_q;
  assign apb_write       = write_q;
  assign apb_addr        = addr_q;
  assign apb_wdata       = wdata_q;
  assign apb_wait_cycles = wait_q;

endmodule
